// File: rtl/mac_pkg.sv
// Shared types and default sizing for the multiply-accumulate block.
package mac_pkg;

    localparam int MAC_WIDTH = 4;
    localparam int MAC_TERMS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

endpackage

// File: rtl/multiplier_csa.sv
// Combinational unsigned multiplier: partial products folded through a
// carry-save chain, then one final carry-propagate add.
module multiplier_csa #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] pp;
    logic [PW-1:0] t;

    always_comb begin
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp = b[i] ? (PW'(a) << i) : '0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        // The true product fits in PW bits, so the dropped carry is always zero.
        p = s + c;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Frame-based multiply-accumulate: TERMS products summed into ACC_W bits.
// Optional build macro MAC_SATURATE_EN clamps the sum instead of wrapping.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int TERMS = MAC_TERMS,
    parameter int ACC_W = 2 * WIDTH + $clog2(TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(TERMS + 1);
    localparam int PW    = 2 * WIDTH;

    // Handshakes: a pair transfers on a rising edge with in_valid && in_ready,
    // a result on a rising edge with out_valid && out_ready; neither ready
    // depends on its own valid.
    mac_state_e       state;
    mac_state_e       state_nxt;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] add_cnt;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             accept;
    logic             add_last;
    logic             release_frame;

    multiplier_csa #(.WIDTH(WIDTH)) u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    assign accept        = in_valid && in_ready;
    assign sum           = {1'b0, acc} + (ACC_W + 1)'(prod_q);
    assign carry         = sum[ACC_W];
    assign add_last      = prod_v && (add_cnt == CNT_W'(TERMS - 1));
    assign release_frame = (state == DONE) && out_ready;
    assign acc_out       = acc;

`ifdef MAC_SATURATE_EN
    assign acc_nxt = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = (accept_cnt < CNT_W'(TERMS));
                if (add_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Two-stage datapath: register the product, then fold it into acc.
    always_ff @(posedge clk) begin
        if (rst || release_frame) begin
            prod_q     <= '0;
            prod_v     <= 1'b0;
            acc        <= '0;
            accept_cnt <= '0;
            add_cnt    <= '0;
            overflow   <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_q     <= prod;
                accept_cnt <= accept_cnt + 1'b1;
            end
            if (prod_v) begin
                acc     <= acc_nxt;
                add_cnt <= add_cnt + 1'b1;
                if (carry) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default, 8-bit accumulator and single-term builds.
module tb_mac_accumulator;

    localparam int W   = 4;
    localparam int AW  = 10;
    localparam int AW8 = 8;
    localparam int AW1 = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, out_valid, out_ready, overflow;
    logic [W-1:0]   a, b;
    logic [AW-1:0]  acc_out;

    logic           in_valid8, in_ready8, out_valid8, out_ready8, overflow8;
    logic [W-1:0]   a8, b8;
    logic [AW8-1:0] acc_out8;

    logic           in_valid1, in_ready1, out_valid1, out_ready1, overflow1;
    logic [W-1:0]   a1, b1;
    logic [AW1-1:0] acc_out1;

    mac_accumulator u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow)
    );

    mac_accumulator #(.WIDTH(4), .TERMS(4), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .acc_out(acc_out8), .overflow(overflow8)
    );

    mac_accumulator #(.WIDTH(4), .TERMS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .acc_out(acc_out1), .overflow(overflow1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [AW:0]  exp_q[$];
    logic [AW8:0] exp_q8[$];
    logic [AW:0]  mon_e;
    logic [AW8:0] mon_e8;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_result", out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_acc", acc_out, mon_e[AW-1:0]);
                check("mon_ovf", overflow, mon_e[AW]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (exp_q8.size() == 0) begin
                check("mon8_unexpected_result", out_valid8, 0);
            end else begin
                mon_e8 = exp_q8.pop_front();
                check("mon8_acc", acc_out8, mon_e8[AW8-1:0]);
                check("mon8_ovf", overflow8, mon_e8[AW8]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb);
        int n;
        n = 0;
        a = aa;
        b = bb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] av, input logic [15:0] bv, input int gap,
                             input logic [AW:0] exp, input string tag);
        exp_q.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            send(av[i*4 +: 4], bv[i*4 +: 4]);
            if (i < 3) idle(gap);
        end
        check({tag, "_valid_early"}, out_valid, 0);
        check({tag, "_in_ready_full"}, in_ready, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_latency"}, out_valid, 1);
        check({tag, "_acc"}, acc_out, exp[AW-1:0]);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_acc"}, acc_out, 0);
        check({tag, "_idle_ovf"}, overflow, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] nom_a, nom_b, zero_a, zero_b, one_v;
    logic [AW8:0] exp8;
    int n8;

    initial begin
        rst = 1'b1;
        in_valid = 0;  a = 0;  b = 0;  out_ready = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; out_ready1 = 0;
        nom_a  = {4'd15, 4'd11, 4'd15, 4'd3};
        nom_b  = {4'd15, 4'd15, 4'd1,  4'd5};
        zero_a = {4'd1, 4'd0, 4'd15, 4'd0};
        zero_b = {4'd0, 4'd0, 4'd0,  4'd15};
        one_v  = {4'd1, 4'd1, 4'd1, 4'd1};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc", acc_out, 0);
        check("rst_ovf", overflow, 0);

        // Nominal back-to-back frame: 15+15+165+225 = 420.
        run_frame(nom_a, nom_b, 0, {1'b0, 10'd420}, "nominal");
        drain("nominal");

        // Same pairs with three idle cycles between them.
        run_frame(nom_a, nom_b, 3, {1'b0, 10'd420}, "gaps");
        drain("gaps");

        // Result held under backpressure; offered pair must be ignored.
        run_frame(nom_a, nom_b, 0, {1'b0, 10'd420}, "bp");
        a = 4'd7;
        b = 4'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_acc_hold", acc_out, 420);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        drain("bp");

        // Zero operands.
        run_frame(zero_a, zero_b, 0, {1'b0, 10'd0}, "zero");
        drain("zero");

        // Reset mid-frame, then a clean frame must not inherit anything.
        send(4'd15, 4'd15);
        send(4'd15, 4'd15);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_acc", acc_out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_ovf", overflow, 0);
        idle(3);
        check("midrst_no_leak_acc", acc_out, 0);
        run_frame(one_v, one_v, 0, {1'b0, 10'd4}, "after_rst");
        drain("after_rst");

        // 8-bit accumulator: 4 x 225 = 900 overflows.
`ifdef MAC_SATURATE_EN
        exp8 = {1'b1, 8'd255};
`else
        exp8 = {1'b1, 8'd132};
`endif
        exp_q8.push_back(exp8);
        a8 = 4'd15;
        b8 = 4'd15;
        in_valid8 = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_valid8 = 1'b0;
        n8 = 0;
        @(negedge clk);
        while (!out_valid8 && n8 < 10) begin
            n8++;
            @(negedge clk);
        end
        check("ovf8_out_valid", out_valid8, 1);
        check("ovf8_flag", overflow8, 1);
        check("ovf8_acc", acc_out8, exp8[AW8-1:0]);
        @(posedge clk);
        #1 out_ready8 = 1'b1;
        @(posedge clk);
        #1 out_ready8 = 1'b0;
        check("ovf8_cleared_acc", acc_out8, 0);
        check("ovf8_cleared_flag", overflow8, 0);

        // Single-term build: 7*9 = 63, result one edge after the add.
        a1 = 4'd7;
        b1 = 4'd9;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        check("t1_valid_early", out_valid1, 0);
        check("t1_in_ready_busy", in_ready1, 0);
        @(posedge clk);
        #1;
        check("t1_valid_latency", out_valid1, 1);
        check("t1_acc", acc_out1, 63);
        check("t1_ovf", overflow1, 0);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        check("t1_idle_in_ready", in_ready1, 1);
        check("t1_idle_acc", acc_out1, 0);

        idle(2);
        check("pending_results", exp_q.size(), 0);
        check("pending_results8", exp_q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
